inst_mem_sim: RTL and testbench
===============================

Name: inst_mem_sim

Overview:
- Parametrised simulation instruction memory feeding the IF stage. Successor of the fixed 16-entry combinational instruction ROM.
- Adds configurable depth and width, a runtime program-load write port, and registered reads.
- Reads use a req/valid handshake with a programmable number of wait states, so IF-stall logic can be exercised before real SRAM is connected.
- Out-of-range fetches return a NOP and raise a flag.

Parameters:
- PC_W, 16, width of the fetch address (matches the PC bus)
- DATA_W, 16, instruction width
- DEPTH, 64, number of words; need not be a power of two
- WAIT_CYCLES, 0, extra cycles between request acceptance and response (0..15)
- NOP_INST, 16'h0800, word returned on out-of-range fetch and used as the power-on fill

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  in  PC_W  fetch word address
- req  in  1  fetch request
- ready  out  1  high when a request can be accepted this cycle
- inst  out  DATA_W  fetched instruction, valid when inst_valid is high
- inst_valid  out  1  one-cycle pulse marking the response
- oob  out  1  qualifies inst_valid: the fetch address was >= DEPTH
- ld_we  in  1  program-load write enable
- ld_addr  in  PC_W  program-load word address
- ld_data  in  DATA_W  program-load data

Behaviour:
- Storage: DEPTH x DATA_W array, filled with NOP_INST at time zero. The array is not cleared by reset, so a loaded program survives rst_n.
- Reset (rst_n low, asynchronous): state=IDLE, ready=1, inst=NOP_INST, inst_valid=0, oob=0, wait counter=0.
- Accept rule: a request is accepted when req && ready at a rising edge. pc is captured on acceptance.
- Data is sampled from the array at the acceptance edge.
  - A same-edge ld_we to the same address does not affect this fetch; the fetch returns the old word.
  - A later ld_we to that address does not affect an in-flight fetch.
- Out-of-range fetch: captured pc >= DEPTH returns inst=NOP_INST with oob=1 alongside inst_valid.
- FSM states IDLE, WAIT, RESP:
  - IDLE: ready=1. On accept, go to RESP if WAIT_CYCLES==0; otherwise load counter=WAIT_CYCLES and go to WAIT.
  - WAIT: ready=0. Decrement the counter each cycle. When counter==1, go to RESP.
  - RESP: inst_valid=1 for exactly one cycle; inst and oob are driven; ready=1. An accept in RESP (back-to-back) re-enters WAIT or RESP by the same rule as IDLE. With no accept, go to IDLE.
- Latency: inst_valid is asserted WAIT_CYCLES+1 cycles after the accepting edge.
  - WAIT_CYCLES=0 gives one response per cycle under continuous req.
  - Throughput is 1/(WAIT_CYCLES+1).
- inst holds its last value after inst_valid drops. oob clears when inst_valid drops.
- req while ready=0 is ignored, not queued. The requester holds req/pc until ready.
- Load port:
  - Writes when ld_we && ld_addr < DEPTH, independent of FSM state.
  - Out-of-range writes are dropped silently.
- Reset mid-fetch (WAIT or RESP): the in-flight fetch is abandoned and no inst_valid is produced after rst_n deasserts.
- Width rules:
  - Index = pc truncated to clog2(DEPTH) bits, used only after the range check on the full PC_W value.
  - Counter width is 4 bits.

Decomposition:
- Shared definitions belong in the existing define include: PC_BUS, INST_BUS, NOP instruction constant, FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- One natural sub-module: inst_mem_array, the synchronous-write / read-at-accept storage with range check and oob output.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then fetch pc=0 without loading, WAIT_CYCLES=0 -> next cycle inst_valid=1, inst=16'h0800, oob=0.
- Load addr0=16'h6801 and addr1=16'h6902, then continuous req with pc=0,1, WAIT_CYCLES=0 -> consecutive cycles return 16'h6801, 16'h6902; ready stays 1.
- WAIT_CYCLES=3, accept pc=1 -> ready=0 for 3 cycles, inst_valid on the 4th edge with inst=16'h6902; req during the wait is ignored.
- Fetch pc=DEPTH (64) -> inst=16'h0800, oob=1 for one cycle. A load to ld_addr=64 leaves the array unchanged; a readback of every index returns the prior contents.
- Same-edge load addr0=16'hE120 and fetch pc=0 -> returns 16'h6801; the next fetch of pc=0 returns 16'hE120.
- WAIT_CYCLES=3, accept, then pulse rst_n low in WAIT -> no inst_valid afterwards, ready=1, inst=16'h0800; the loaded program is still readable.

Source files
------------

// File: rtl/inst_mem_sim_pkg.sv
// Shared widths, constants, FSM encoding and helpers for the simulation
// instruction memory.
package inst_mem_sim_pkg;

   localparam int unsigned PC_BUS_W     = 16;
   localparam int unsigned INST_BUS_W   = 16;
   localparam logic [15:0] NOP_INST_DEF = 16'h0800;
   localparam int unsigned CNT_W        = 4;

   typedef logic [CNT_W-1:0] wcnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Index width for a DEPTH-entry array; at least one bit.
   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/inst_mem_sim_if.sv
// Fetch handshake and program-load bus between the IF stage (master) and
// the instruction memory (slave).
interface inst_mem_sim_if #(
   parameter int unsigned PC_W   = inst_mem_sim_pkg::PC_BUS_W,
   parameter int unsigned DATA_W = inst_mem_sim_pkg::INST_BUS_W
) ();

   logic [PC_W-1:0]   pc;
   logic              req;
   logic              ready;
   logic [DATA_W-1:0] inst;
   logic              inst_valid;
   logic              oob;
   logic              ld_we;
   logic [PC_W-1:0]   ld_addr;
   logic [DATA_W-1:0] ld_data;

   modport master (
      output pc, req, ld_we, ld_addr, ld_data,
      input  ready, inst, inst_valid, oob
   );

   modport slave (
      input  pc, req, ld_we, ld_addr, ld_data,
      output ready, inst, inst_valid, oob
   );

endinterface

// File: rtl/inst_mem_sim_array.sv
// DEPTH x DATA_W storage: range-checked synchronous write, live range-checked
// lookup, and a capture register that freezes the looked-up word on accept.
module inst_mem_array
   import inst_mem_sim_pkg::*;
#(
   parameter int unsigned       PC_W     = PC_BUS_W,
   parameter int unsigned       DATA_W   = INST_BUS_W,
   parameter int unsigned       DEPTH    = 64,
   parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   rd_addr_i,
   input  logic              rd_cap_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_oob_o,
   output logic [DATA_W-1:0] cap_data_o,
   output logic              cap_oob_o,
   input  logic              wr_en_i,
   input  logic [PC_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   localparam int unsigned AW = idx_w(DEPTH);

   // Power-on fill only; reset leaves a loaded program intact.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_INST};

   logic              rd_in_range;
   logic              wr_in_range;
   logic [DATA_W-1:0] cap_data_q;
   logic              cap_oob_q;

   // Range check uses the full address before truncating to the index.
   assign rd_in_range = 32'(rd_addr_i) < DEPTH;
   assign wr_in_range = 32'(wr_addr_i) < DEPTH;

   assign rd_data_o  = rd_in_range ? mem_q[rd_addr_i[AW-1:0]] : NOP_INST;
   assign rd_oob_o   = ~rd_in_range;
   assign cap_data_o = cap_data_q;
   assign cap_oob_o  = cap_oob_q;

   always_ff @(posedge clk) begin
      if (wr_en_i && wr_in_range) begin
         mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_data_q <= NOP_INST;
         cap_oob_q  <= 1'b0;
      end else if (rd_cap_i) begin
         cap_data_q <= rd_data_o;
         cap_oob_q  <= ~rd_in_range;
      end
   end

endmodule

// File: rtl/inst_mem_sim.sv
// Simulation instruction memory: registered reads behind a req/ready/valid
// handshake with WAIT_CYCLES programmable wait states and a program-load port.
module inst_mem_sim
   import inst_mem_sim_pkg::*;
#(
   parameter int unsigned       PC_W        = PC_BUS_W,
   parameter int unsigned       DATA_W      = INST_BUS_W,
   parameter int unsigned       DEPTH       = 64,
   parameter int unsigned       WAIT_CYCLES = 0,
   parameter logic [DATA_W-1:0] NOP_INST    = DATA_W'(NOP_INST_DEF)
) (
   input logic           clk,
   input logic           rst_n,
   inst_mem_sim_if.slave bus
);

   localparam wcnt_t WAIT_CNT = wcnt_t'(WAIT_CYCLES);

   state_e            state_q, state_d;
   wcnt_t             cnt_q, cnt_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic              oob_q, oob_d;

   logic              ready;
   logic              accept;
   logic [DATA_W-1:0] lk_data;
   logic              lk_oob;
   logic [DATA_W-1:0] cap_data;
   logic              cap_oob;

   assign ready  = (state_q != WAIT);
   assign accept = bus.req && ready;

   assign bus.ready      = ready;
   assign bus.inst       = inst_q;
   assign bus.inst_valid = (state_q == RESP);
   assign bus.oob        = oob_q;

   inst_mem_array #(
      .PC_W     (PC_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .NOP_INST (NOP_INST)
   ) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (bus.pc),
      .rd_cap_i   (accept),
      .rd_data_o  (lk_data),
      .rd_oob_o   (lk_oob),
      .cap_data_o (cap_data),
      .cap_oob_o  (cap_oob),
      .wr_en_i    (bus.ld_we),
      .wr_addr_i  (bus.ld_addr),
      .wr_data_i  (bus.ld_data)
   );

   // inst only changes on entry to RESP so it holds across idle and wait
   // cycles; a zero-wait response takes the live lookup, otherwise the
   // word captured at the accepting edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inst_d  = inst_q;
      oob_d   = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  inst_d  = lk_data;
                  oob_d   = lk_oob;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_CNT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == wcnt_t'(1)) begin
               state_d = RESP;
               inst_d  = cap_data;
               oob_d   = cap_oob;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         inst_q  <= NOP_INST;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         oob_q   <= oob_d;
      end
   end

endmodule

// File: tb/tb_inst_mem_sim.sv
// Bench for inst_mem_sim: a zero-wait and a three-wait instance, table-driven
// fetch/load vectors plus hand sequences, responses checked via scoreboards.
module tb_inst_mem_sim;

   localparam int unsigned DEPTH = 64;
   localparam logic [15:0] NOP   = 16'h0800;
   localparam int          NV    = 11;

   typedef struct {
      logic [15:0] inst;
      logic        oob;
   } exp_t;

   typedef struct {
      logic        ld_we;
      logic [15:0] ld_addr;
      logic [15:0] ld_data;
      logic        req;
      logic [15:0] pc;
      logic        exp_ready;
      logic [15:0] exp_inst;
      logic        exp_oob;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n0;
   logic rst_n3;

   inst_mem_sim_if #(.PC_W(16), .DATA_W(16)) bus0 ();
   inst_mem_sim_if #(.PC_W(16), .DATA_W(16)) bus3 ();

   inst_mem_sim #(
      .PC_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0), .NOP_INST(NOP)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n0),
      .bus   (bus0)
   );

   inst_mem_sim #(
      .PC_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(3), .NOP_INST(NOP)
   ) dut3 (
      .clk   (clk),
      .rst_n (rst_n3),
      .bus   (bus3)
   );

   int          checks = 0;
   int          errors = 0;
   exp_t        q0[$];
   exp_t        q3[$];
   logic [15:0] last0 = NOP;
   logic [15:0] last3 = NOP;
   logic [15:0] model [DEPTH];
   vec_t        tv [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic mon0();
      exp_t e;
      if (!rst_n0) begin
         last0 = NOP;
      end else if (bus0.inst_valid === 1'b1) begin
         if (q0.size() == 0) begin
            chk("w0_unexpected_valid", 32'(bus0.inst_valid), 32'd0);
         end else begin
            e = q0.pop_front();
            chk("w0_inst", 32'(bus0.inst), 32'(e.inst));
            chk("w0_oob", 32'(bus0.oob), 32'(e.oob));
            last0 = e.inst;
         end
      end else begin
         chk("w0_inst_hold", 32'(bus0.inst), 32'(last0));
         chk("w0_oob_low", 32'(bus0.oob), 32'd0);
      end
   endtask

   task automatic mon3();
      exp_t e;
      if (!rst_n3) begin
         last3 = NOP;
      end else if (bus3.inst_valid === 1'b1) begin
         if (q3.size() == 0) begin
            chk("w3_unexpected_valid", 32'(bus3.inst_valid), 32'd0);
         end else begin
            e = q3.pop_front();
            chk("w3_inst", 32'(bus3.inst), 32'(e.inst));
            chk("w3_oob", 32'(bus3.oob), 32'(e.oob));
            last3 = e.inst;
         end
      end else begin
         chk("w3_inst_hold", 32'(bus3.inst), 32'(last3));
         chk("w3_oob_low", 32'(bus3.oob), 32'd0);
      end
   endtask

   // One clock: inputs set before the call are taken at the posedge, outputs
   // are sampled at the following negedge.
   task automatic step();
      @(negedge clk);
      mon0();
      mon3();
   endtask

   function automatic vec_t mkv(input logic we, input logic [15:0] la, input logic [15:0] ld,
                                input logic rq, input logic [15:0] pc,
                                input logic [15:0] ei, input logic eo);
      vec_t v;
      v.ld_we = we; v.ld_addr = la; v.ld_data = ld;
      v.req = rq; v.pc = pc;
      v.exp_ready = 1'b1; v.exp_inst = ei; v.exp_oob = eo;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      tv[0]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd0,     NOP,      1'b0);
      tv[1]  = mkv(1'b1, 16'd0,  16'h6801, 1'b0, 16'd0,     16'h0000, 1'b0);
      tv[2]  = mkv(1'b1, 16'd1,  16'h6902, 1'b0, 16'd0,     16'h0000, 1'b0);
      tv[3]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd0,     16'h6801, 1'b0);
      tv[4]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd1,     16'h6902, 1'b0);
      tv[5]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd64,    NOP,      1'b1);
      tv[6]  = mkv(1'b1, 16'd64, 16'hBEEF, 1'b0, 16'd0,     16'h0000, 1'b0);
      tv[7]  = mkv(1'b1, 16'd0,  16'hE120, 1'b1, 16'd0,     16'h6801, 1'b0);
      tv[8]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd0,     16'hE120, 1'b0);
      tv[9]  = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'd63,    NOP,      1'b0);
      tv[10] = mkv(1'b0, 16'd0,  16'h0000, 1'b1, 16'h0041,  NOP,      1'b1);
      for (int unsigned i = 0; i < DEPTH; i++) model[i] = NOP;

      rst_n0 = 1'b0; rst_n3 = 1'b0;
      bus0.req = 1'b0; bus0.pc = '0; bus0.ld_we = 1'b0; bus0.ld_addr = '0; bus0.ld_data = '0;
      bus3.req = 1'b0; bus3.pc = '0; bus3.ld_we = 1'b0; bus3.ld_addr = '0; bus3.ld_data = '0;
      repeat (2) step();
      chk("rst_ready",  32'(bus0.ready), 32'd1);
      chk("rst_inst",   32'(bus0.inst), 32'(NOP));
      chk("rst_valid",  32'(bus0.inst_valid), 32'd0);
      chk("rst_oob",    32'(bus0.oob), 32'd0);
      chk("rst3_ready", 32'(bus3.ready), 32'd1);
      rst_n0 = 1'b1; rst_n3 = 1'b1;
      step();

      // Zero-wait instance: table of load/fetch vectors
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("w0_ready_v%0d", i), 32'(bus0.ready), 32'(tv[i].exp_ready));
         bus0.ld_we = tv[i].ld_we; bus0.ld_addr = tv[i].ld_addr; bus0.ld_data = tv[i].ld_data;
         bus0.req = tv[i].req; bus0.pc = tv[i].pc;
         if (tv[i].req) q0.push_back('{tv[i].exp_inst, tv[i].exp_oob});
         if (tv[i].ld_we && 32'(tv[i].ld_addr) < DEPTH) model[tv[i].ld_addr] = tv[i].ld_data;
         step();
      end
      bus0.ld_we = 1'b0; bus0.req = 1'b0;
      for (int k = 0; k < 20 && q0.size() != 0; k++) step();
      chk("w0_drain_table", 32'(q0.size()), 32'd0);

      // Full readback after the dropped out-of-range load
      for (int unsigned i = 0; i < DEPTH; i++) begin
         bus0.req = 1'b1; bus0.pc = 16'(i);
         q0.push_back('{model[i], 1'b0});
         step();
      end
      bus0.req = 1'b0;
      for (int k = 0; k < 20 && q0.size() != 0; k++) step();
      chk("w0_drain_readback", 32'(q0.size()), 32'd0);

      // Three-wait instance: latency, ignored req during wait
      bus3.ld_we = 1'b1; bus3.ld_addr = 16'd1; bus3.ld_data = 16'h6902;
      step();
      bus3.ld_we = 1'b0;
      chk("w3_ready_idle", 32'(bus3.ready), 32'd1);
      bus3.req = 1'b1; bus3.pc = 16'd1;
      q3.push_back('{16'h6902, 1'b0});
      step();
      bus3.pc = 16'd5;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("w3_ready_wait%0d", k), 32'(bus3.ready), 32'd0);
         chk($sformatf("w3_valid_wait%0d", k), 32'(bus3.inst_valid), 32'd0);
         step();
      end
      bus3.req = 1'b0;
      chk("w3_valid_4th_edge", 32'(bus3.inst_valid), 32'd1);
      chk("w3_ready_resp", 32'(bus3.ready), 32'd1);
      repeat (4) step();
      chk("w3_drain_wait", 32'(q3.size()), 32'd0);

      // Reset during WAIT abandons the fetch; program survives
      bus3.req = 1'b1; bus3.pc = 16'd1;
      step();
      bus3.req = 1'b0;
      step();
      rst_n3 = 1'b0;
      #1;
      chk("w3_rst_ready", 32'(bus3.ready), 32'd1);
      chk("w3_rst_inst",  32'(bus3.inst), 32'(NOP));
      chk("w3_rst_valid", 32'(bus3.inst_valid), 32'd0);
      chk("w3_rst_oob",   32'(bus3.oob), 32'd0);
      step();
      rst_n3 = 1'b1;
      repeat (6) step();
      chk("w3_ready_after_rst", 32'(bus3.ready), 32'd1);
      bus3.req = 1'b1; bus3.pc = 16'd1;
      q3.push_back('{16'h6902, 1'b0});
      step();
      bus3.req = 1'b0;
      for (int k = 0; k < 20 && q3.size() != 0; k++) step();
      chk("w3_drain_after_rst", 32'(q3.size()), 32'd0);
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
